jtframe_debug_pager: RTL
========================

Name: jtframe_debug_pager

Overview:
- Frame-synchronous scheduler that time-shares the single 8-bit debug OSD overlay between PAGES debug views.
- Selects the displayed view by manual keys, by auto-cycling, or by a requester forcing its view for a fixed number of frames (round-robin among requesters).
- Sits between core debug sources and the debug overlay logic; its osd_data output drives the overlay value input.
- All outputs change only at frame boundaries so the overlay never tears mid-frame.

Parameters:
- PAGES, 4, number of 8-bit views; legal range 2..16. PGW = clog2(PAGES) is a localparam.
- FRAMES, 60, frames per page in auto mode; legal range 1..255.
- HOLD, 120, frames a forced (requested) page stays on screen; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- lvbl  in  1  vertical blank, active-low; the frame boundary (fb) is its falling edge.
- page_next  in  1  key level; each rising edge requests a +1 page step.
- page_prev  in  1  key level; each rising edge requests a -1 page step.
- auto_en  in  1  selects auto-cycling when no page is forced.
- req  in  PAGES  per-view force request; a rising edge latches a pending request.
- views  in  8*PAGES  view i is views[8*i+7:8*i].
- osd_data  out  8  byte to overlay, registered.
- osd_page  out  PGW  index of the displayed view, registered.
- osd_valid  out  1  overlay enable, registered.
- gnt  out  PAGES  one-hot level; high while that requester's page is forced.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0. Also cleared: cur_page, saved_page, frame_cnt, hold_cnt, the pending bits, rr_ptr and the edge-detect registers. State = MANUAL.
- fb detection:
  - lvbl_l is registered every clk; fb = lvbl_l & ~lvbl, a 1-cycle pulse.
  - The first lvbl sample after reset does not produce fb.
- Key stepping:
  - Key rising edges are captured on any clk into step_pend (+1 or -1).
  - A later edge overwrites an earlier one; simultaneous next and prev edges clear step_pend.
  - step_pend is applied and cleared at the next fb.
  - Keys seen while in FORCE are discarded at fb.
- Request capture: a req[i] rising edge sets pend[i] on any clk. Deasserting req does not cancel pend[i].
- State machine; all transitions happen only on fb:
  - MANUAL: any pend bit -> FORCE. Else apply step_pend to cur_page modulo PAGES (wraps in both directions). If auto_en -> AUTO with frame_cnt=0.
  - AUTO:
    - Any pend bit -> FORCE.
    - Else if step_pend: apply the step and set frame_cnt=0.
    - Else if frame_cnt==FRAMES-1: frame_cnt=0 and cur_page+1 (wrap PAGES-1 -> 0).
    - Otherwise frame_cnt+1.
    - If !auto_en -> MANUAL; frame_cnt holds.
  - Entering FORCE:
    - Winner w = first set pend bit searching from rr_ptr upward, modulo PAGES.
    - pend[w] cleared; gnt = 1<<w; hold_cnt = HOLD-1; saved_page = cur_page; rr_ptr = (w+1) mod PAGES.
  - FORCE:
    - If hold_cnt==0: gnt=0; cur_page = saved_page; next state = AUTO if auto_en else MANUAL, with frame_cnt=0. Pending requests are examined at the following fb, not the same one.
    - Otherwise hold_cnt-1.
    - A new req[w] edge during its own grant sets pend[w] again and is served later in round-robin order.
- Output update, same fb, using the post-transition state:
  - disp = w in FORCE, else cur_page.
  - osd_page = disp; osd_data = view[disp] sampled at that fb.
  - osd_valid = 1 in FORCE, else (view[disp] != 0).
- Latency: a key or request edge is visible on outputs 1 clk after the next fb. osd_data stays frozen between fbs.
- An fb and a req edge in the same cycle: the edge is latched but not arbitrated until the next fb.

Optional Feature:
- Macro: JTFRAME_DEBUG_PAGER_BLINK_EN.
- Defined: in FORCE, osd_valid = ~hold_cnt[3], so the forced page blinks with an 8-frame on/off period.
- Undefined: osd_valid is held at 1 for the whole FORCE period.

Test Plan:
- Reset then MANUAL, views = {8'h44, 8'h33, 8'h22, 8'h11}; pulse page_prev once, one fb -> osd_page=3, osd_data=8'h44, osd_valid=1.
- MANUAL, page 1 selected and view1 = 0; one fb -> osd_valid=0 and osd_data=0.
- auto_en=1, FRAMES=2 -> page sequence across fbs is 0,0,1,1,2,2,3,3,0 (wrap confirmed).
- req[2] and req[0] both rise while rr_ptr=1, HOLD=3:
  - gnt=4'b0100 for exactly 3 fbs, with osd_page=2 throughout.
  - After release, one fb shows the saved cur_page.
  - The next fb gives gnt=4'b0001.
- During FORCE, pulse page_next -> cur_page unchanged after the grant ends.
- Assert rst_n=0 mid-FORCE (not at a clk edge) -> gnt, osd_* and pend go to 0 immediately. After release, the first fb shows page 0.

Source files
------------

// File: rtl/jtframe_debug_pager.sv
// jtframe_debug_pager
//   Frame-synchronous scheduler that time-shares the 8-bit debug OSD overlay
//   between PAGES debug views. A view is chosen by manual keys, by
//   auto-cycling, or by a requester forcing its view for HOLD frames, with
//   round-robin arbitration among requesters. All outputs update only on
//   the frame boundary (falling edge of lvbl), so the overlay never tears.
//
//   Optional build macro: JTFRAME_DEBUG_PAGER_BLINK_EN
//     defined   : a forced page blinks (osd_valid = ~hold_cnt[3])
//     undefined : osd_valid stays 1 for the whole forced period
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   lvbl       vertical blank, active-low; its falling edge is the frame boundary
//   page_next  key level, rising edge requests +1 page
//   page_prev  key level, rising edge requests -1 page
//   auto_en    auto-cycle pages when nothing is forced
//   req        per-view force request, rising edge latches a pending request
//   views      view i is views[8*i+7:8*i]
//   osd_data   byte sent to the overlay (registered)
//   osd_page   index of the displayed view (registered)
//   osd_valid  overlay enable (registered)
//   gnt        one-hot, high while that requester's page is forced
module jtframe_debug_pager #(
    parameter int PAGES  = 4,
    parameter int FRAMES = 60,
    parameter int HOLD   = 120,
    localparam int PGW   = $clog2(PAGES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lvbl,
    input  logic                 page_next,
    input  logic                 page_prev,
    input  logic                 auto_en,
    input  logic [PAGES-1:0]     req,
    input  logic [8*PAGES-1:0]   views,
    output logic [7:0]           osd_data,
    output logic [PGW-1:0]       osd_page,
    output logic                 osd_valid,
    output logic [PAGES-1:0]     gnt
);

    typedef enum logic [1:0] { MANUAL, AUTO, FORCE } state_t;

    state_t             state, state_nxt;
    logic               lvbl_l, next_l, prev_l, fb;
    logic               next_edge, prev_edge;
    logic               step_up, step_dn;
    logic [PAGES-1:0]   req_l, pend, pend_clr;
    logic [PGW-1:0]     cur_page, saved_page, rr_ptr, win;
    logic [PGW-1:0]     cur_nxt, saved_nxt, rr_nxt, win_nxt;
    logic [PGW-1:0]     step_page, inc_page, pick, disp;
    logic [PGW:0]       sum;
    logic               found;
    logic [7:0]         frame_cnt, hold_cnt, frame_nxt, hold_nxt;
    logic [7:0]         disp_view;
    logic               valid_nxt, force_valid;
    logic [PAGES-1:0]   gnt_nxt;

    assign fb        = lvbl_l & ~lvbl;
    assign next_edge = page_next & ~next_l;
    assign prev_edge = page_prev & ~prev_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MANUAL;
        else if (fb) state <= state_nxt;
    end

    always_comb begin
        // round-robin search: first pending bit at or above rr_ptr, wrapping
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int unsigned i = 0; i < PAGES; i++) begin
            sum = {1'b0, rr_ptr} + (PGW+1)'(i);
            if (sum >= (PGW+1)'(PAGES)) sum = sum - (PGW+1)'(PAGES);
            if (!found && pend[sum[PGW-1:0]]) begin
                found = 1'b1;
                pick  = sum[PGW-1:0];
            end
        end

        inc_page  = (cur_page == PGW'(PAGES-1)) ? '0 : cur_page + PGW'(1);
        step_page = cur_page;
        if (step_up)      step_page = inc_page;
        else if (step_dn) step_page = (cur_page == '0) ? PGW'(PAGES-1) : cur_page - PGW'(1);

        state_nxt = state;
        cur_nxt   = cur_page;
        saved_nxt = saved_page;
        rr_nxt    = rr_ptr;
        win_nxt   = win;
        frame_nxt = frame_cnt;
        hold_nxt  = hold_cnt;
        pend_clr  = '0;

        if (state != FORCE && found) begin
            state_nxt   = FORCE;
            win_nxt     = pick;
            pend_clr    = '0;
            pend_clr[pick] = 1'b1;
            hold_nxt    = 8'(HOLD-1);
            saved_nxt   = cur_page;
            rr_nxt      = (pick == PGW'(PAGES-1)) ? '0 : pick + PGW'(1);
        end else begin
            case (state)
                MANUAL: begin
                    cur_nxt = step_page;
                    if (auto_en) begin
                        state_nxt = AUTO;
                        frame_nxt = '0;
                    end
                end
                AUTO: begin
                    if (!auto_en) begin
                        state_nxt = MANUAL;
                        cur_nxt   = step_page;
                    end else if (step_up || step_dn) begin
                        cur_nxt   = step_page;
                        frame_nxt = '0;
                    end else if (frame_cnt == 8'(FRAMES-1)) begin
                        cur_nxt   = inc_page;
                        frame_nxt = '0;
                    end else begin
                        frame_nxt = frame_cnt + 8'd1;
                    end
                end
                FORCE: begin
                    if (hold_cnt == '0) begin
                        state_nxt = auto_en ? AUTO : MANUAL;
                        frame_nxt = '0;
                        cur_nxt   = saved_page;
                    end else begin
                        hold_nxt = hold_cnt - 8'd1;
                    end
                end
                default: state_nxt = MANUAL;
            endcase
        end

        disp      = (state_nxt == FORCE) ? win_nxt : cur_nxt;
        disp_view = '0;
        for (int unsigned i = 0; i < PAGES; i++) begin
            if (disp == PGW'(i)) disp_view = views[8*i +: 8];
        end

`ifdef JTFRAME_DEBUG_PAGER_BLINK_EN
        force_valid = ~hold_nxt[3];
`else
        force_valid = 1'b1;
`endif
        valid_nxt = (state_nxt == FORCE) ? force_valid : (disp_view != 8'd0);
        gnt_nxt   = (state_nxt == FORCE) ? (PAGES'(1) << win_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvbl_l     <= 1'b0;
            next_l     <= 1'b0;
            prev_l     <= 1'b0;
            req_l      <= '0;
            pend       <= '0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            cur_page   <= '0;
            saved_page <= '0;
            rr_ptr     <= '0;
            win        <= '0;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
            osd_data   <= '0;
            osd_page   <= '0;
            osd_valid  <= 1'b0;
            gnt        <= '0;
        end else begin
            lvbl_l <= lvbl;
            next_l <= page_next;
            prev_l <= page_prev;
            req_l  <= req;
            // a request edge coinciding with its own clear wins, so it is served again later
            pend   <= (pend & ~(fb ? pend_clr : '0)) | (req & ~req_l);
            // newest key edge overrides; simultaneous edges cancel; fb consumes it
            if (next_edge || prev_edge) begin
                step_up <= next_edge & ~prev_edge;
                step_dn <= prev_edge & ~next_edge;
            end else if (fb) begin
                step_up <= 1'b0;
                step_dn <= 1'b0;
            end
            if (fb) begin
                cur_page   <= cur_nxt;
                saved_page <= saved_nxt;
                rr_ptr     <= rr_nxt;
                win        <= win_nxt;
                frame_cnt  <= frame_nxt;
                hold_cnt   <= hold_nxt;
                osd_data   <= disp_view;
                osd_page   <= disp;
                osd_valid  <= valid_nxt;
                gnt        <= gnt_nxt;
            end
        end
    end

endmodule
